// File: rtl/ones_comp_muldiv_seq_if.sv
// Request/response bundle for the iterative one's-complement multiply/divide unit.
// The sequencer side uses the master modport. The arithmetic unit uses the slave modport.
interface ones_comp_muldiv_seq_if #(
    parameter int WIDTH = 15
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] numer_hi;
    logic [WIDTH-1:0] numer_lo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, op, x, y, numer_hi, numer_lo,
        input  busy, done, result_hi, result_lo, div_zero, overflow
    );

    modport slave (
        input  start, op, x, y, numer_hi, numer_lo,
        output busy, done, result_hi, result_lo, div_zero, overflow
    );
endinterface

// File: rtl/ones_comp_muldiv_seq.sv
// Iterative one's-complement multiply / divide for the AGC ALU.
// Multiply is shift-add over a 2M-bit accumulator, taking one bit of x per cycle, LSB first.
// Divide is restoring division, producing one quotient bit per cycle, MSB first.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   CALC  | M iterations of the datapath, counter M-1 down to 0
//   DONE  | one-cycle done pulse; results and flags are valid
module ones_comp_muldiv_seq #(
    parameter int WIDTH = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ones_comp_muldiv_seq_if.slave  bus
);
    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand split into sign and magnitude. Each word is decoded with its own sign bit.
    logic         sx, sy, sn, s_lo;
    logic [M-1:0] mag_x, mag_y, mag_nh, mag_nl;
    logic         x_zero, quot_ovf, accept;

    // Datapath registers
    logic           op_q;
    logic [M-1:0]   opnd_q;
    logic [2*M-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           sgn_hi_q, sgn_lo_q;
    logic [WIDTH-1:0] result_hi_q, result_lo_q;
    logic           div_zero_q, overflow_q, busy_q, done_q;

    // Combinational values for one iteration
    logic [M:0]     mul_sum;
    logic [M:0]     div_trial;
    logic           div_ge;
    logic [2*M-1:0] acc_next;
    logic [M-1:0]   hi_mag, lo_mag;
    logic [WIDTH-1:0] pack_hi, pack_lo;

    // Decode operand signs and magnitudes, and evaluate the divide pre-checks
    always_comb begin
        sx       = bus.x[M];
        sy       = bus.y[M];
        sn       = bus.numer_hi[M];
        s_lo     = bus.numer_lo[M];
        mag_x    = sx   ? ~bus.x[M-1:0]        : bus.x[M-1:0];
        mag_y    = sy   ? ~bus.y[M-1:0]        : bus.y[M-1:0];
        mag_nh   = sn   ? ~bus.numer_hi[M-1:0] : bus.numer_hi[M-1:0];
        mag_nl   = s_lo ? ~bus.numer_lo[M-1:0] : bus.numer_lo[M-1:0];
        x_zero   = (mag_x == '0);
        quot_ovf = (mag_nh >= mag_x);
        accept   = (state_q == IDLE) && bus.start;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Divides that fail a pre-check skip CALC and go straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op && (x_zero || quot_ovf)) begin
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One iteration of shift-add or restoring divide, plus result packing on the last step.
    // For divide, the upper half of acc holds the partial remainder and the lower half
    // shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*M-1:M]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q[2*M-1:M], acc_q[M-1]} - {1'b0, opnd_q};
        div_ge    = ~div_trial[M];
        if (op_q) begin
            acc_next = div_ge ? {div_trial[M-1:0], acc_q[M-2:0], 1'b1}
                              : {acc_q[2*M-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc_q[M-1:1]};
        end
        hi_mag  = op_q ? acc_next[M-1:0]   : acc_next[2*M-1:M];
        lo_mag  = op_q ? acc_next[2*M-1:M] : acc_next[M-1:0];
        pack_hi = {sgn_hi_q, sgn_hi_q ? ~hi_mag : hi_mag};
        pack_lo = {sgn_lo_q, sgn_lo_q ? ~lo_mag : lo_mag};
    end

    // Capture operands on accept, iterate in CALC, and register all outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sgn_hi_q    <= 1'b0;
            sgn_lo_q    <= 1'b0;
            result_hi_q <= '0;
            result_lo_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q        <= bus.op;
                cnt_q       <= CW'(M - 1);
                result_hi_q <= '0;
                result_lo_q <= '0;
                div_zero_q  <= bus.op & x_zero;
                overflow_q  <= bus.op & ~x_zero & quot_ovf;
                if (bus.op) begin
                    opnd_q   <= mag_x;
                    acc_q    <= {mag_nh, mag_nl};
                    sgn_hi_q <= sn ^ sx;
                    sgn_lo_q <= sn;
                end else begin
                    opnd_q   <= mag_y;
                    acc_q    <= {{M{1'b0}}, mag_x};
                    sgn_hi_q <= sx ^ sy;
                    sgn_lo_q <= sx ^ sy;
                end
            end else if (state_q == CALC) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    result_hi_q <= pack_hi;
                    result_lo_q <= pack_lo;
                end
            end
            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_hi = result_hi_q;
    assign bus.result_lo = result_lo_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ones_comp_muldiv_seq.sv
// Bench for ones_comp_muldiv_seq. It drives three instances, at WIDTH 15, 8 and 24,
// and checks them against a one's-complement reference model through a scoreboard queue.
module tb_ones_comp_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_v [3];
    logic        op_v    [3];
    logic [31:0] x_v [3], y_v [3], nh_v [3], nl_v [3];
    logic        busy_o [3], done_o [3], dz_o [3], ov_o [3];
    logic [31:0] rh_o [3], rl_o [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 15 : ((g == 1) ? 8 : 24);
        ones_comp_muldiv_seq_if #(.WIDTH(W)) bus ();
        assign bus.start    = start_v[g];
        assign bus.op       = op_v[g];
        assign bus.x        = x_v[g][W-1:0];
        assign bus.y        = y_v[g][W-1:0];
        assign bus.numer_hi = nh_v[g][W-1:0];
        assign bus.numer_lo = nl_v[g][W-1:0];
        assign busy_o[g]    = bus.busy;
        assign done_o[g]    = bus.done;
        assign dz_o[g]      = bus.div_zero;
        assign ov_o[g]      = bus.overflow;
        assign rh_o[g]      = 32'(bus.result_hi);
        assign rl_o[g]      = 32'(bus.result_lo);
        ones_comp_muldiv_seq #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    typedef struct {
        logic [31:0] rh;
        logic [31:0] rl;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int passed = 0;
    int total  = 0;

    logic [31:0] obs_rh, obs_rl;
    logic        obs_dz, obs_ov, obs_to, obs_busy1;
    int          obs_lat;

    function automatic int wid(input int k);
        return (k == 0) ? 15 : ((k == 1) ? 8 : 24);
    endfunction

    function automatic void model(input int w, input logic op,
                                  input logic [31:0] x, y, nh, nl,
                                  output logic [31:0] rh, rl, output logic dz, ov);
        int m;
        logic [63:0] mk, mx, my, mh, ml, p, d, q, r, hi, lo;
        logic sx, sy, sn, sl, s;
        m  = w - 1;
        mk = (64'd1 << m) - 64'd1;
        sx = x[m]; sy = y[m]; sn = nh[m]; sl = nl[m];
        mx = sx ? (~{32'd0, x} & mk) : ({32'd0, x} & mk);
        my = sy ? (~{32'd0, y} & mk) : ({32'd0, y} & mk);
        mh = sn ? (~{32'd0, nh} & mk) : ({32'd0, nh} & mk);
        ml = sl ? (~{32'd0, nl} & mk) : ({32'd0, nl} & mk);
        rh = '0; rl = '0; dz = 1'b0; ov = 1'b0;
        if (!op) begin
            p  = mx * my;
            s  = sx ^ sy;
            hi = p >> m;
            lo = p & mk;
            if (s) begin
                hi = ~hi & mk;
                lo = ~lo & mk;
            end
            rh = 32'(({63'd0, s} << m) | hi);
            rl = 32'(({63'd0, s} << m) | lo);
        end else if (mx == 0) begin
            dz = 1'b1;
        end else if (mh >= mx) begin
            ov = 1'b1;
        end else begin
            d = (mh << m) | ml;
            q = d / mx;
            r = d % mx;
            if (sn ^ sx) q = ~q & mk;
            if (sn) r = ~r & mk;
            rh = 32'(({63'd0, sn ^ sx} << m) | q);
            rl = 32'(({63'd0, sn} << m) | r);
        end
    endfunction

    // Push the expectation, issue one operation, and wait (bounded) for done.
    // If glitch > 0, pulse start with scrambled operands at that cycle of the operation.
    task automatic drive_op(input int k, input logic op, input logic [31:0] x, y, nh, nl,
                            input int glitch);
        exp_t e;
        int   n;
        int   g;
        model(wid(k), op, x, y, nh, nl, e.rh, e.rl, e.dz, e.ov);
        e.lat = (op && (e.dz || e.ov)) ? 1 : wid(k);
        g = 0;
        @(negedge clk);
        while (busy_o[k] && g < 100) begin
            @(negedge clk);
            g++;
        end
        op_v[k] = op; x_v[k] = x; y_v[k] = y; nh_v[k] = nh; nl_v[k] = nl;
        start_v[k] = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        obs_busy1 = busy_o[k];
        n = 1;
        while (!done_o[k] && n < 200) begin
            if (n == glitch) begin
                start_v[k] = 1'b1; op_v[k] = ~op; x_v[k] = ~x; y_v[k] = ~y; nh_v[k] = '0;
            end else begin
                start_v[k] = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_v[k] = 1'b0;
        obs_to  = !done_o[k];
        obs_lat = n;
        obs_rh  = rh_o[k]; obs_rl = rl_o[k]; obs_dz = dz_o[k]; obs_ov = ov_o[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({busy_o[k], done_o[k], dz_o[k], ov_o[k], rh_o[k], rl_o[k]} !== '0)
                $display("FAIL reset[w%0d]: busy=%b done=%b dz=%b ov=%b hi=%h lo=%h, expected all 0",
                         wid(k), busy_o[k], done_o[k], dz_o[k], ov_o[k], rh_o[k], rl_o[k]);
            else passed++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] tx [4] = '{32'h0003, 32'h7FFC, 32'h0000, 32'h7FFC};
        logic [31:0] ty [4] = '{32'h0005, 32'h0005, 32'h7FFA, 32'h7FFA};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_op(0, 1'b0, tx[i], ty[i], 32'h0, 32'h0, 0);
            e = sb_q.pop_front();
            total++;
            if (obs_to || {obs_rh, obs_rl, obs_dz, obs_ov} !== {e.rh, e.rl, e.dz, e.ov})
                $display("FAIL mul[%0d]: timeout=%b got %h/%h dz=%b ov=%b, expected %h/%h dz=%b ov=%b",
                         i, obs_to, obs_rh, obs_rl, obs_dz, obs_ov, e.rh, e.rl, e.dz, e.ov);
            else passed++;
            total++;
            if (obs_lat !== e.lat || obs_busy1 !== 1'b1)
                $display("FAIL mul_lat[%0d]: latency %0d busy %b, expected %0d busy 1",
                         i, obs_lat, obs_busy1, e.lat);
            else passed++;
        end
    endtask

    task automatic test_div();
        logic [31:0] tnh [5] = '{32'h0000, 32'h7FFF, 32'h0000, 32'h0007, 32'h0002};
        logic [31:0] tnl [5] = '{32'h0064, 32'h7F9B, 32'h0064, 32'h0000, 32'h1234};
        logic [31:0] tx  [5] = '{32'h0007, 32'h0007, 32'h7FFF, 32'h0007, 32'h7FF0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drive_op(0, 1'b1, tx[i], 32'h0, tnh[i], tnl[i], 0);
            e = sb_q.pop_front();
            total++;
            if (obs_to || {obs_rh, obs_rl, obs_dz, obs_ov} !== {e.rh, e.rl, e.dz, e.ov})
                $display("FAIL div[%0d]: timeout=%b got %h/%h dz=%b ov=%b, expected %h/%h dz=%b ov=%b",
                         i, obs_to, obs_rh, obs_rl, obs_dz, obs_ov, e.rh, e.rl, e.dz, e.ov);
            else passed++;
            total++;
            if (obs_lat !== e.lat)
                $display("FAIL div_lat[%0d]: latency %0d, expected %0d", i, obs_lat, e.lat);
            else passed++;
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        drive_op(0, 1'b0, 32'h0003, 32'h0005, 32'h0, 32'h0, 4);
        e = sb_q.pop_front();
        total++;
        if (obs_to || {obs_rh, obs_rl, obs_dz, obs_ov, obs_lat} !== {e.rh, e.rl, e.dz, e.ov, e.lat})
            $display("FAIL start_ignored: got %h/%h dz=%b ov=%b lat=%0d, expected %h/%h dz=%b ov=%b lat=%0d",
                     obs_rh, obs_rl, obs_dz, obs_ov, obs_lat, e.rh, e.rl, e.dz, e.ov, e.lat);
        else passed++;
    endtask

    task automatic test_abort();
        exp_t e;
        logic seen;
        drive_op(0, 1'b0, 32'h7FFC, 32'h0005, 32'h0, 32'h0, 0);
        e = sb_q.pop_front();
        total++;
        if (obs_to || {obs_rh, obs_rl} !== {e.rh, e.rl})
            $display("FAIL abort_pre: got %h/%h, expected %h/%h", obs_rh, obs_rl, e.rh, e.rl);
        else passed++;
        @(negedge clk);
        op_v[0] = 1'b0; x_v[0] = 32'h0003; y_v[0] = 32'h0005; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({busy_o[0], done_o[0], dz_o[0], ov_o[0], rh_o[0], rl_o[0]} !== '0)
            $display("FAIL abort_outputs: busy=%b done=%b dz=%b ov=%b hi=%h lo=%h, expected all 0",
                     busy_o[0], done_o[0], dz_o[0], ov_o[0], rh_o[0], rl_o[0]);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_o[0] || busy_o[0]) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0)
            $display("FAIL abort_no_done: busy/done seen=%b, expected 0", seen);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   dn [3];
        int   cnt;
        int   n;
        int   g;
        cnt = 0;
        @(negedge clk);
        op_v[1] = 1'b0; x_v[1] = 32'h06; y_v[1] = 32'h7A;
        for (int i = 0; i < 3; i++) begin
            model(8, 1'b0, 32'h06, 32'h7A, 32'h0, 32'h0, e.rh, e.rl, e.dz, e.ov);
            e.lat = 8;
            sb_q.push_back(e);
        end
        start_v[1] = 1'b1;
        n = 0;
        while (cnt < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (done_o[1]) begin
                dn[cnt] = n;
                e = sb_q.pop_front();
                total++;
                if ({rh_o[1], rl_o[1], dz_o[1], ov_o[1]} !== {e.rh, e.rl, e.dz, e.ov})
                    $display("FAIL b2b_result[%0d]: got %h/%h, expected %h/%h",
                             cnt, rh_o[1], rl_o[1], e.rh, e.rl);
                else passed++;
                cnt++;
            end
        end
        start_v[1] = 1'b0;
        total++;
        if (cnt !== 3 || (dn[1] - dn[0]) !== 9 || (dn[2] - dn[1]) !== 9)
            $display("FAIL b2b_spacing: dones=%0d gaps %0d,%0d, expected 3 dones gaps 9,9",
                     cnt, dn[1] - dn[0], dn[2] - dn[1]);
        else passed++;
        while (sb_q.size() > 0) void'(sb_q.pop_front());
        g = 0;
        while (busy_o[1] && g < 50) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int w, m;
        logic [31:0] wm, mk, x, y, nh, nl, mx, mh;
        logic op;
        for (int k = 0; k < 3; k++) begin
            w  = wid(k);
            m  = w - 1;
            wm = 32'((64'd1 << w) - 64'd1);
            mk = 32'((64'd1 << m) - 64'd1);
            for (int i = 0; i < 30; i++) begin
                op = 1'($urandom_range(0, 1));
                x  = $urandom & wm; y = $urandom & wm;
                nh = $urandom & wm; nl = $urandom & wm;
                if (op && $urandom_range(0, 3) != 0) begin
                    mx = x[m] ? (~x & mk) : (x & mk);
                    if (mx != 0) begin
                        mh = $urandom_range(0, mx - 1);
                        nh = nh[m] ? ((~mh & mk) | (32'd1 << m)) : mh;
                    end
                end
                drive_op(k, op, x, y, nh, nl, 0);
                e = sb_q.pop_front();
                total++;
                if (obs_to || {obs_rh, obs_rl, obs_dz, obs_ov, obs_lat} !== {e.rh, e.rl, e.dz, e.ov, e.lat})
                    $display("FAIL sweep_w%0d[%0d]: op=%b x=%h y=%h n=%h/%h got %h/%h dz=%b ov=%b lat=%0d, expected %h/%h dz=%b ov=%b lat=%0d",
                             w, i, op, x, y, nh, nl, obs_rh, obs_rl, obs_dz, obs_ov, obs_lat,
                             e.rh, e.rl, e.dz, e.ov, e.lat);
                else passed++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; op_v[k] = 1'b0;
            x_v[k] = '0; y_v[k] = '0; nh_v[k] = '0; nl_v[k] = '0;
        end
        test_reset();
        test_mul();
        test_div();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end
endmodule
